// File: rtl/dip_reader_pkg.sv
// dip_reader_pkg: shared FSM encoding and parameter-range checks for the DIP-switch reader.
package dip_reader_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

    localparam int MIN_CLK_DIV = 4;
    localparam int MIN_N_BITS  = 2;
    localparam int MAX_N_BITS  = 16;

    function automatic bit params_ok(input int n_bits, input int clk_div, input int latch_ticks);
        return clk_div >= MIN_CLK_DIV && n_bits >= MIN_N_BITS && n_bits <= MAX_N_BITS && latch_ticks >= 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: phase counter with synchronous restart; tick is high for one cycle every DIV cycles.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic i_CLK,
    input  logic i_SYS_RESET,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge i_CLK or negedge i_SYS_RESET)
        if (!i_SYS_RESET)
            cnt <= '0;
        else
            cnt <= restart || tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/dip_reader.sv
// dip_reader: drives a 74HC165-style shift register and presents the switch word, MSB shifted in first.
module dip_reader
    import dip_reader_pkg::*;
#(
    parameter int N_BITS      = 8,
    parameter int CLK_DIV     = 4,
    parameter int LATCH_TICKS = 1,
    parameter bit AUTO_MODE   = 1'b0
) (
    input  logic              i_CLK,
    input  logic              i_SYS_RESET,
    input  logic              i_start,
    input  logic              i_DIPData,
    output logic              o_DIPLatch,
    output logic              o_DIPClk,
    output logic [N_BITS-1:0] o_data,
    output logic              o_valid,
    output logic              o_changed,
    output logic              o_busy
);

    localparam int BW = $clog2(N_BITS);
    localparam int LW = LATCH_TICKS > 1 ? $clog2(LATCH_TICKS) : 1;

    if (!params_ok(N_BITS, CLK_DIV, LATCH_TICKS)) begin : g_bad_params
        $error("dip_reader: parameter out of range");
    end

    state_t            state, state_nx;
    logic [1:0]        sync;
    logic [BW-1:0]     bit_cnt;
    logic [LW-1:0]     lat_cnt;
    logic [N_BITS-1:0] shreg;
    logic              first;
    logic              tick;
    logic              d;

    assign d      = sync[1];
    assign o_busy = state != IDLE;

    tick_gen #(.DIV(CLK_DIV)) u_tick (
        .i_CLK       (i_CLK),
        .i_SYS_RESET (i_SYS_RESET),
        .restart     (state_nx != state),
        .tick        (tick)
    );

    // In auto mode IDLE is left unconditionally, so the reader free-runs from reset onward.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = AUTO_MODE || i_start ? LOAD : IDLE;
            LOAD:     state_nx = tick && lat_cnt == LW'(LATCH_TICKS - 1) ? SHIFT_LO : LOAD;
            SHIFT_LO: state_nx = !tick ? SHIFT_LO : bit_cnt == BW'(N_BITS - 1) ? DONE : SHIFT_HI;
            SHIFT_HI: state_nx = tick ? SHIFT_LO : SHIFT_HI;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_SYS_RESET)
        if (!i_SYS_RESET) begin
            state      <= IDLE;
            sync       <= '0;
            bit_cnt    <= '0;
            lat_cnt    <= '0;
            shreg      <= '0;
            first      <= 1'b1;
            o_DIPLatch <= 1'b1;
            o_DIPClk   <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_changed  <= 1'b0;
        end else begin
            state      <= state_nx;
            sync       <= {sync[0], i_DIPData};
            // Pin outputs follow the next state so they change exactly on state boundaries.
            o_DIPLatch <= state_nx != LOAD;
            o_DIPClk   <= state_nx == SHIFT_HI;
            lat_cnt    <= state != LOAD ? '0 : lat_cnt + LW'(tick && state_nx == LOAD);
            bit_cnt    <= state == LOAD ? '0 : bit_cnt + BW'(state == SHIFT_LO && state_nx == SHIFT_HI);
            if (state == SHIFT_LO && tick)
                shreg <= {shreg[N_BITS-2:0], d};
            o_valid    <= state == DONE;
            o_changed  <= state == DONE && (first || shreg != o_data);
            if (state == DONE) begin
                o_data <= shreg;
                first  <= 1'b0;
            end
        end

endmodule
